cube_sort_sched: RTL and testbench

- Sequential scheduler for the 16-node hypercube compare-exchange sorter.
- Accepts N keys serially into an internal node register file.
- Sequences the full bitonic network of compare-exchange stages, one stage per cycle, over a shared bank of N/2 comparators.
- Streams sorted keys out serially under valid/ready handshakes.

---
 rtl/cube_sort_pkg.sv | 28 ++
 rtl/cube_sort_sched_if.sv | 32 +++
 rtl/cube_cmp_xchg.sv | 26 ++
 rtl/cube_sort_sched.sv | 161 ++++++++++++++++
 tb/tb_cube_sort_sched.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/cube_sort_pkg.sv
// -----------------------------------------------------------------------------
// cube_sort_pkg
// Shared types and constants for the hypercube compare-exchange sorter.
//   key_t       : default key type (KEY_W-bit unsigned)
//   state_t     : scheduler FSM states LOAD / SORT / DRAIN
//   num_stages  : bitonic stage count for a given log2(N)
//   NUM_STAGES  : stage count for the default 16-node build
// No ports (package).
// -----------------------------------------------------------------------------
package cube_sort_pkg;

   localparam int KEY_W = 16;

   typedef logic [KEY_W-1:0] key_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int num_stages(input int log_n);
      return log_n * (log_n + 1) / 2;
   endfunction

   localparam int NUM_STAGES = num_stages(4);

endpackage

// File: rtl/cube_sort_sched_if.sv
// -----------------------------------------------------------------------------
// cube_sort_sched_if
// Key-in / key-out handshake bundle of the sorter scheduler.
//   in_valid/in_ready/in_data            : serial key load (producer -> sorter)
//   out_valid/out_ready/out_data/out_last : serial sorted stream (sorter -> consumer)
//   busy                                  : sorter is in SORT or DRAIN
// Modports:
//   master : the environment (drives keys in, accepts sorted keys)
//   slave  : the scheduler
// -----------------------------------------------------------------------------
interface cube_sort_sched_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/cube_cmp_xchg.sv
// -----------------------------------------------------------------------------
// cube_cmp_xchg
// Combinational compare-exchange of two unsigned keys.
//   a, b  in  W : keys from the lower-index node and its partner
//   desc  in  1 : 0 = place smaller key on lo, 1 = place larger key on lo
//   lo    out W : key for the lower-index node
//   hi    out W : key for the partner node
// Equal keys are never swapped, so ties pass straight through.
// -----------------------------------------------------------------------------
module cube_cmp_xchg #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         desc,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);
   logic swap;

   always_comb begin
      swap = desc ? (a < b) : (a > b);
      lo   = swap ? b : a;
      hi   = swap ? a : b;
   end
endmodule

// File: rtl/cube_sort_sched.sv
// -----------------------------------------------------------------------------
// cube_sort_sched
// Sequential scheduler for an N-node hypercube bitonic sorter. Keys are loaded
// serially into a node register file, the full bitonic network is run one
// stage per cycle over N/2 shared compare-exchange units, and the sorted keys
// are streamed out serially.
// Ports:
//   clk  in  : rising-edge clock
//   rst  in  : synchronous active-high reset (aborts any batch)
//   bus  slave modport of cube_sort_sched_if:
//        in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_last, busy
// Build option:
//   CUBE_SORT_DESC_EN : when defined, keys stream out largest first.
// -----------------------------------------------------------------------------
module cube_sort_sched
   import cube_sort_pkg::*;
#(
   parameter int N     = 16,
   parameter int LOG_N = 4,
   parameter int W     = 16
) (
   input logic              clk,
   input logic              rst,
   cube_sort_sched_if.slave bus
);

   localparam int HALF = N / 2;

`ifdef CUBE_SORT_DESC_EN
   localparam logic DIR_INV = 1'b1;
`else
   localparam logic DIR_INV = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [LOG_N-1:0] idx_q, idx_d;
   logic [LOG_N-1:0] oidx_q, oidx_d;
   logic [LOG_N:0]   k_q, k_d;     // block size, one-hot, 2..N
   logic [LOG_N-1:0] j_q, j_d;     // partner distance, one-hot, k/2..1
   logic [W-1:0]     node_q [N];
   logic [W-1:0]     node_d [N];

   logic             in_ready_c;
   logic             out_valid_c;
   logic             in_hs;
   logic             out_hs;

   logic [LOG_N-1:0] low_mask;
   logic [LOG_N-1:0] cv       [HALF];
   logic [LOG_N-1:0] pair_i   [HALF];
   logic [LOG_N-1:0] pair_p   [HALF];
   logic             cmp_desc [HALF];
   logic [W-1:0]     cmp_lo   [HALF];
   logic [W-1:0]     cmp_hi   [HALF];

   // Comparator c serves the pair whose lower index is c with a 0 inserted at
   // bit position log2(j); its partner has that bit set. This enumerates every
   // i < i^j exactly once.
   always_comb begin
      low_mask = j_q - LOG_N'(1);
      for (int c = 0; c < HALF; c++) begin
         cv[c]       = LOG_N'(c);
         pair_i[c]   = ((cv[c] & ~low_mask) << 1) | (cv[c] & low_mask);
         pair_p[c]   = pair_i[c] | j_q;
         cmp_desc[c] = (|(pair_i[c] & k_q[LOG_N-1:0])) ^ DIR_INV;
      end
   end

   for (genvar g = 0; g < HALF; g++) begin : g_cmp
      cube_cmp_xchg #(.W(W)) u_cmp (
         .a    (node_q[pair_i[g]]),
         .b    (node_q[pair_p[g]]),
         .desc (cmp_desc[g]),
         .lo   (cmp_lo[g]),
         .hi   (cmp_hi[g])
      );
   end

   assign in_hs  = bus.in_valid && in_ready_c;
   assign out_hs = out_valid_c && bus.out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= '0;
         oidx_q  <= '0;
         k_q     <= '0;
         j_q     <= '0;
         for (int n = 0; n < N; n++) node_q[n] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         oidx_q  <= oidx_d;
         k_q     <= k_d;
         j_q     <= j_d;
         node_q  <= node_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      oidx_d  = oidx_q;
      k_d     = k_q;
      j_d     = j_q;
      node_d  = node_q;
      case (state_q)
         LOAD: begin
            if (in_hs) begin
               node_d[idx_q] = bus.in_data;
               idx_d         = idx_q + LOG_N'(1);
               if (idx_q == LOG_N'(N - 1)) begin
                  state_d = SORT;
                  k_d     = (LOG_N + 1)'(2);
                  j_d     = LOG_N'(1);
               end
            end
         end
         SORT: begin
            // All exchanges read node_q, so the whole stage commits at once.
            for (int c = 0; c < HALF; c++) begin
               node_d[pair_i[c]] = cmp_lo[c];
               node_d[pair_p[c]] = cmp_hi[c];
            end
            if (j_q == LOG_N'(1)) begin
               if (k_q == (LOG_N + 1)'(N)) begin
                  state_d = DRAIN;
                  k_d     = '0;
                  j_d     = '0;
               end else begin
                  k_d = k_q << 1;
                  j_d = k_q[LOG_N-1:0];
               end
            end else begin
               j_d = j_q >> 1;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               oidx_d = oidx_q + LOG_N'(1);
               if (oidx_q == LOG_N'(N - 1)) state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Outputs; forced idle while rst is high
   always_comb begin
      in_ready_c    = !rst && (state_q == LOAD);
      out_valid_c   = !rst && (state_q == DRAIN);
      bus.in_ready  = in_ready_c;
      bus.out_valid = out_valid_c;
      bus.out_data  = out_valid_c ? node_q[oidx_q] : '0;
      bus.out_last  = out_valid_c && (oidx_q == LOG_N'(N - 1));
      bus.busy      = !rst && (state_q != LOAD);
   end

endmodule

// File: tb/tb_cube_sort_sched.sv
// -----------------------------------------------------------------------------
// tb_cube_sort_sched
// Directed bench for cube_sort_sched (N=16, W=16). Honours CUBE_SORT_DESC_EN
// by reversing the expected order.
// -----------------------------------------------------------------------------
module tb_cube_sort_sched;
   import cube_sort_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   key_t keys    [16];
   key_t exp_asc [16];
   key_t exp_o   [16];
   int   lat;

   cube_sort_sched_if #(.W(16)) bus ();

   cube_sort_sched #(.N(16), .LOG_N(4), .W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic order(input key_t a[16], output key_t e[16]);
      for (int i = 0; i < 16; i++) begin
`ifdef CUBE_SORT_DESC_EN
         e[i] = a[15 - i];
`else
         e[i] = a[i];
`endif
      end
   endtask

   task automatic load16(input key_t k[16], input bit dead_after);
      for (int n = 0; n < 16; n++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = k[n];
         #1;
         chk("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      if (dead_after) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'hDEAD;
      end else begin
         bus.in_valid = 1'b0;
      end
      #1;
      chk("in_ready_sort", {31'd0, bus.in_ready}, 32'd0);
      chk("busy_sort", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic wait_first(output int l);
      l = 0;
      while (!bus.out_valid && l < 50) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic drain16(input key_t e[16], input bit bp);
      int  n = 0;
      int  guard = 0;
      bit  hs;
      while (n < 16 && guard < 2000) begin
         bus.out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
         #1;
         chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("out_data", {16'd0, bus.out_data}, {16'd0, e[n]});
         chk("out_last", {31'd0, bus.out_last}, {31'd0, (n == 15)});
         chk("in_ready_drain", {31'd0, bus.in_ready}, 32'd0);
         hs = bus.out_ready;
         @(posedge clk); #1;
         if (hs) n++;
         guard++;
      end
      if (n < 16) chk("drain_timeout", 32'd0, 32'd1);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      #1;
      chk("out_valid_end", {31'd0, bus.out_valid}, 32'd0);
      chk("in_ready_end", {31'd0, bus.in_ready}, 32'd1);
      chk("busy_end", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset values
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
      chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Reverse order, out_ready held high even during load (must be ignored)
      for (int i = 0; i < 16; i++) begin
         keys[i]    = key_t'(15 - i);
         exp_asc[i] = key_t'(i);
      end
      order(exp_asc, exp_o);
      bus.out_ready = 1'b1;
      load16(keys, 1'b0);
      wait_first(lat);
      chk("latency_rev", lat, 32'd10);
      drain16(exp_o, 1'b0);

      // Extremes and duplicates
      keys    = '{16'hFFFF, 16'h0000, 16'h0007, 16'h0007, 16'h8000, 16'h0001, 16'h0007, 16'h0000,
                  16'h7FFF, 16'h7FFE, 16'h0002, 16'h8001, 16'h0003, 16'hFFFE, 16'h0000, 16'h0001};
      exp_asc = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0007,
                  16'h0007, 16'h0007, 16'h7FFE, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF};
      order(exp_asc, exp_o);
      load16(keys, 1'b0);
      wait_first(lat);
      chk("latency_ext", lat, 32'd10);
      drain16(exp_o, 1'b0);

      // Backpressure at ~30% out_ready duty
      keys    = '{16'h00A5, 16'h003C, 16'h00FF, 16'h0000, 16'h0010, 16'h0090, 16'h0042, 16'h0042,
                  16'h007F, 16'h0080, 16'h0001, 16'h00EE, 16'h005A, 16'h00C3, 16'h002B, 16'h0099};
      exp_asc = '{16'h0000, 16'h0001, 16'h0010, 16'h002B, 16'h003C, 16'h0042, 16'h0042, 16'h005A,
                  16'h007F, 16'h0080, 16'h0090, 16'h0099, 16'h00A5, 16'h00C3, 16'h00EE, 16'h00FF};
      order(exp_asc, exp_o);
      load16(keys, 1'b0);
      wait_first(lat);
      chk("latency_bp", lat, 32'd10);
      drain16(exp_o, 1'b1);

      // in_valid with 0xDEAD held through SORT and DRAIN
      keys    = '{16'h5555, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h1111, 16'hEEEE, 16'h2222, 16'hDDDD,
                  16'h3333, 16'hCCCC, 16'h4444, 16'hBBBB, 16'h6666, 16'h9999, 16'h7777, 16'h8888};
      exp_asc = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777,
                  16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
      order(exp_asc, exp_o);
      load16(keys, 1'b1);
      wait_first(lat);
      chk("latency_dead", lat, 32'd10);
      drain16(exp_o, 1'b1);

      // The batch after the ignored-input run must load cleanly
      for (int i = 0; i < 16; i++) begin
         keys[i]    = key_t'(16'h0100 + 16'((i * 7) % 16));
         exp_asc[i] = key_t'(16'h0100 + 16'(i));
      end
      order(exp_asc, exp_o);
      load16(keys, 1'b0);
      wait_first(lat);
      chk("latency_after_dead", lat, 32'd10);
      drain16(exp_o, 1'b0);

      // Reset on the 5th SORT cycle
      load16(keys, 1'b0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("midsort_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midsort_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("midsort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("midsort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midsort_busy_after", {31'd0, bus.busy}, 32'd0);

      // Fresh random batch, expected order from an insertion sort
      for (int i = 0; i < 16; i++) begin
         keys[i]    = key_t'($urandom_range(0, 65535));
         exp_asc[i] = keys[i];
      end
      for (int i = 1; i < 16; i++) begin
         for (int m = i; m > 0 && exp_asc[m-1] > exp_asc[m]; m--) begin
            key_t t;
            t            = exp_asc[m];
            exp_asc[m]   = exp_asc[m-1];
            exp_asc[m-1] = t;
         end
      end
      order(exp_asc, exp_o);
      load16(keys, 1'b0);
      wait_first(lat);
      chk("latency_rand", lat, 32'd10);
      drain16(exp_o, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
